mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit. It consumes the E->M pipeline bundle produced by the execute stage and drives the data-memory bus through a req/gnt/rvalid handshake. It formats load data and stalls the upstream pipeline while an access is outstanding. It also owns the M->W pipeline register that feeds write-back.

Parameters:
TIMEOUT_CYCLES, 255, cycles in REQ+WAIT before an access is abandoned with a bus error (1..65535)
XLEN, 32, datapath width (only 32 is supported)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
ALUResultM  input  32  effective address, or ALU result for non-memory ops
WriteDataM  input  32  store data (already forwarded)
MemWriteM  input  2  00 none, 01 SB, 10 SH, 11 SW
ResultSrcM  input  2  00 ALU, 01 load, 10 PC+4
LoadTypeM  input  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
RegWriteM  input  3  write-enable/type code, passed through (nonzero = write)
RDM  input  5  destination register
PCPlus4M  input  32  PC+4
dmem_req  output  1  bus request
dmem_we  output  1  1 = store
dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_gnt  input  1  bus accepted request this cycle
dmem_rvalid  input  1  access complete; rdata valid for loads
dmem_rdata  input  32  read word
StallM  output  1  to hazard unit: hold F/D/E/M
BusErrM  output  1  one-cycle pulse on timeout
MisalignM  output  1  one-cycle pulse on misaligned access (macro only)
ALUResultW, ReadDataW, PCPlus4W  output  32 each  M->W register
RDW  output  5  M->W register
RegWriteW  output  3  M->W register
ResultSrcW  output  2  M->W register

Behaviour:
- Reset: clk/rst fixed as stated (one clock; synchronous active-high rst). On rst=1 the state goes to IDLE, the timeout counter clears and every registered output becomes 0. dmem_req, StallM, BusErrM and MisalignM are 0 in the reset cycle. A reset mid-REQ/WAIT abandons the access; a later dmem_rvalid arriving in IDLE is ignored.
- A cycle is a memory op when MemWriteM!=00 or ResultSrcM==01.
- IDLE:
  - Non-memory op: StallM=0; the W regs capture the inputs at the edge. Latency is 1 cycle.
  - Memory op: StallM=1 and the next state is REQ. The W regs capture a bubble (RegWriteW<=0, other W fields hold).
- REQ:
  - dmem_req=1; addr, we, be and wdata are driven from the held M inputs and stay stable until dmem_gnt.
  - dmem_gnt=1 moves to WAIT. StallM=1.
- WAIT:
  - dmem_req=0 and StallM=1 until dmem_rvalid.
  - In the rvalid cycle: StallM=0; the W regs capture the inputs, with ReadDataW set to the formatted rdata (loads) or 0 (stores). Next state is IDLE.
  - Stores also wait for rvalid, which acts as the write acknowledge.
  - Minimum memory-op latency is 3 cycles in M (IDLE, REQ with gnt, WAIT with rvalid).
- Timeout:
  - The counter clears on entering REQ and increments each REQ/WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without completion: BusErrM=1 for that cycle, StallM=0, the W regs capture with RegWriteW=0, next state is IDLE.
  - If rvalid arrives in the same cycle as expiry, rvalid wins and no error is raised.
- Stall bubble: in every cycle with StallM=1 the W regs load RegWriteW=0, so no duplicate write-back occurs.
- Store lanes (off = addr[1:0]):
  - SB: wdata={4{wd[7:0]}}, be=0001<<off.
  - SH: wdata={2{wd[15:0]}}, be=0011<<off.
  - SW: wdata=wd, be=1111.
  - Loads: we=0, be=1111.
- Load format:
  - LB/LBU select rdata byte off, then sign-/zero-extend.
  - LH/LHU select the halfword at off[1] (rdata[31:16] if off[1]=1, else rdata[15:0]), then extend.
  - LW passes the word through.
  - Unlisted LoadTypeM values are treated as LW.
- Misaligned access: a halfword access with addr[0]=1, or a word access with addr[1:0]!=00.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a misaligned memory op in IDLE issues no bus access and is handled in the IDLE cycle:
  - MisalignM=1 for that cycle and StallM=0.
  - The W regs capture with RegWriteW=0.
  - Store data is suppressed.
- Undefined:
  - MisalignM is tied to 0.
  - The offset is forced aligned (half: bit0 cleared; word: bits[1:0] cleared) and the access proceeds normally.

Test Plan:
- SW addr 0x0000_0100, data 0xDEADBEEF, gnt in REQ, rvalid next cycle:
  - dmem_addr 0x100, be 1111, wdata 0xDEADBEEF.
  - StallM high 2 cycles, then low in the rvalid cycle.
  - RegWriteW stays 0.
- LB addr 0x103 with rdata 0x80FF_0000, then LBU at the same address:
  - LB: ReadDataW=0xFFFF_FF80.
  - LBU: ReadDataW=0x0000_0080.
  - RegWriteW=RegWriteM, RDW correct.
- SH addr 0x102, data 0x0000_1234, gnt delayed 3 cycles:
  - dmem_req held with addr 0x100, be 1100, wdata 0x1234_1234 stable all 4 REQ cycles.
  - StallM extended accordingly.
- TIMEOUT_CYCLES=8, load granted, no rvalid:
  - BusErrM pulses exactly once, on the 8th REQ/WAIT cycle.
  - State returns to IDLE; RegWriteW=0.
  - Back-to-back ALU op then completes in 1 cycle.
- LW addr 0x102:
  - MISALIGN_TRAP_EN defined: MisalignM pulse, no dmem_req, StallM 0.
  - Undefined: dmem_addr 0x100, normal 3-cycle load.
- rst=1 asserted in WAIT, then rvalid the next cycle:
  - All outputs 0, state IDLE.
  - The late rvalid causes no W update.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives the data-memory req/gnt/rvalid bus,
// formats load data, stalls upstream while an access is outstanding and owns
// the M->W pipeline register.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned accesses trap in IDLE
// instead of being force-aligned onto the bus).
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [1:0]      MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      LoadTypeM,
    input  logic [2:0]      RegWriteM,
    input  logic [4:0]      RDM,
    input  logic [XLEN-1:0] PCPlus4M,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            StallM,
    output logic            BusErrM,
    output logic            MisalignM,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [4:0]      RDW,
    output logic [2:0]      RegWriteW,
    output logic [1:0]      ResultSrcW
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state, state_next;
    logic [15:0] tmo_cnt;
    logic        expire;

    logic        is_store, is_load, mem_op;
    logic [1:0]  acc_size;
    logic        misaligned;
    logic        trap;
    logic [1:0]  off;
    logic [31:0] load_fmt;
    logic [31:0] rdata_w;

    // W-register update controls produced by the output logic
    logic        cap_ok;
    logic        cap_err;

    // Select and extend the requested byte/halfword from the returned word
    function automatic logic [31:0] fmt_load(input logic [31:0] rdata,
                                             input logic [2:0]  lt,
                                             input logic [1:0]  o);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = rdata >> {o, 3'b000};
        b  = sh[7:0];
        h  = o[1] ? rdata[31:16] : rdata[15:0];
        case (lt)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'd0, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = rdata;
        endcase
    endfunction

    // Decode access kind, size, alignment and effective byte offset
    always_comb begin
        is_store = (MemWriteM != 2'b00);
        is_load  = (ResultSrcM == 2'b01);
        mem_op   = is_store || is_load;
        if (is_store) begin
            case (MemWriteM)
                2'b01:   acc_size = SZ_BYTE;
                2'b10:   acc_size = SZ_HALF;
                default: acc_size = SZ_WORD;
            endcase
        end else begin
            case (LoadTypeM)
                3'b000, 3'b100: acc_size = SZ_BYTE;
                3'b001, 3'b101: acc_size = SZ_HALF;
                default:        acc_size = SZ_WORD;
            endcase
        end
        misaligned = mem_op &&
                     (((acc_size == SZ_HALF) && ALUResultM[0]) ||
                      ((acc_size == SZ_WORD) && (ALUResultM[1:0] != 2'b00)));
`ifdef MISALIGN_TRAP_EN
        trap = misaligned;
        off  = ALUResultM[1:0];
`else
        trap = 1'b0;
        case (acc_size)
            SZ_HALF: off = {ALUResultM[1], 1'b0};
            SZ_WORD: off = 2'b00;
            default: off = ALUResultM[1:0];
        endcase
`endif
    end

    // Bus address, write enable, byte enables and lane-replicated store data
    always_comb begin
        dmem_addr  = {ALUResultM[31:2], 2'b00};
        dmem_we    = is_store;
        dmem_be    = 4'b1111;
        dmem_wdata = 32'd0;
        if (is_store && !trap) begin
            case (acc_size)
                SZ_BYTE: begin
                    dmem_wdata = {4{WriteDataM[7:0]}};
                    dmem_be    = 4'b0001 << off;
                end
                SZ_HALF: begin
                    dmem_wdata = {2{WriteDataM[15:0]}};
                    dmem_be    = 4'b0011 << off;
                end
                default: begin
                    dmem_wdata = WriteDataM;
                    dmem_be    = 4'b1111;
                end
            endcase
        end else if (trap) begin
            dmem_be = 4'b0000;
        end
        load_fmt = fmt_load(dmem_rdata, LoadTypeM, off);
        rdata_w  = is_load ? load_fmt : 32'd0;
    end

    assign expire = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (mem_op && !trap) state_next = S_REQ;
            S_REQ: begin
                if (expire)        state_next = S_IDLE;
                else if (dmem_gnt) state_next = S_WAIT;
            end
            S_WAIT: if (dmem_rvalid || expire) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: bus request, stall, error pulses and W-register controls
    always_comb begin
        dmem_req  = 1'b0;
        StallM    = 1'b0;
        BusErrM   = 1'b0;
        MisalignM = 1'b0;
        cap_ok    = 1'b0;
        cap_err   = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (!mem_op) begin
                        cap_ok = 1'b1;
                    end else if (trap) begin
                        MisalignM = 1'b1;
                        cap_err   = 1'b1;
                    end else begin
                        StallM = 1'b1;
                    end
                end
                S_REQ: begin
                    if (expire) begin
                        BusErrM = 1'b1;
                        cap_err = 1'b1;
                    end else begin
                        dmem_req = 1'b1;
                        StallM   = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        cap_ok = 1'b1;
                    end else if (expire) begin
                        BusErrM = 1'b1;
                        cap_err = 1'b1;
                    end else begin
                        StallM = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timeout counter: zero in IDLE so it starts at 0 in the first REQ cycle
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) tmo_cnt <= 16'd0;
        else                        tmo_cnt <= tmo_cnt + 16'd1;
    end

    // M->W register: capture on completion, bubble (RegWriteW=0) otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RDW        <= '0;
            RegWriteW  <= '0;
            ResultSrcW <= '0;
        end else if (cap_ok || cap_err) begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= cap_ok ? rdata_w : 32'd0;
            PCPlus4W   <= PCPlus4M;
            RDW        <= RDM;
            RegWriteW  <= cap_ok ? RegWriteM : 3'd0;
            ResultSrcW <= ResultSrcM;
        end else begin
            RegWriteW <= 3'd0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a scoreboard of expected W-register
// contents, pushed when an op is driven and popped when the op completes.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  MemWriteM, ResultSrcM;
    logic [2:0]  LoadTypeM, RegWriteM;
    logic [4:0]  RDM;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        StallM, BusErrM, MisalignM;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RDW;
    logic [2:0]  RegWriteW;
    logic [1:0]  ResultSrcW;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  rw;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [1:0]  rs;
    } exp_t;
    exp_t sb[$];

    mem_stage_lsu #(.TIMEOUT_CYCLES(8), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM), .RegWriteM(RegWriteM),
        .RDM(RDM), .PCPlus4M(PCPlus4M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .BusErrM(BusErrM), .MisalignM(MisalignM),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RDW(RDW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // drive an op and push its expected W contents
    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [1:0] mw,
                         input logic [1:0] rs, input logic [2:0] lt, input logic [2:0] rw,
                         input logic [4:0] rd, input logic [31:0] pc,
                         input logic [2:0] xrw, input logic [31:0] xrdata);
        exp_t e;
        ALUResultM = alu; WriteDataM = wd; MemWriteM = mw; ResultSrcM = rs;
        LoadTypeM = lt; RegWriteM = rw; RDM = rd; PCPlus4M = pc;
        e.rw = xrw; e.rd = rd; e.alu = alu; e.rdata = xrdata; e.pc = pc; e.rs = rs;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_RegWriteW"},  32'(RegWriteW),  32'(e.rw));
            chk({tag, "_RDW"},        32'(RDW),        32'(e.rd));
            chk({tag, "_ALUResultW"}, ALUResultW,      e.alu);
            chk({tag, "_ReadDataW"},  ReadDataW,       e.rdata);
            chk({tag, "_PCPlus4W"},   PCPlus4W,        e.pc);
            chk({tag, "_ResultSrcW"}, 32'(ResultSrcW), 32'(e.rs));
        end
    endtask

    // run a driven memory op through IDLE, REQ (gdly wait cycles), WAIT (rdly)
    task automatic mem_op(input string tag, input int gdly, input int rdly,
                          input logic [31:0] rdata, input logic [31:0] xaddr,
                          input logic [3:0] xbe, input logic [31:0] xwd, input logic xwe);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = rdata;
        #4;
        chk({tag, "_idle_stall"}, 32'(StallM), 32'd1);
        chk({tag, "_idle_req"},   32'(dmem_req), 32'd0);
        cyc();
        chk({tag, "_idle_bubble"}, 32'(RegWriteW), 32'd0);
        for (int i = 0; i <= gdly; i++) begin
            dmem_gnt = (i == gdly);
            #4;
            chk({tag, "_req"},   32'(dmem_req), 32'd1);
            chk({tag, "_stall"}, 32'(StallM), 32'd1);
            chk({tag, "_addr"},  dmem_addr, xaddr);
            chk({tag, "_be"},    32'(dmem_be), 32'(xbe));
            chk({tag, "_we"},    32'(dmem_we), 32'(xwe));
            if (xwe) chk({tag, "_wdata"}, dmem_wdata, xwd);
            cyc();
            chk({tag, "_req_bubble"}, 32'(RegWriteW), 32'd0);
        end
        dmem_gnt = 1'b0;
        for (int i = 0; i <= rdly; i++) begin
            dmem_rvalid = (i == rdly);
            #4;
            chk({tag, "_wait_req"},   32'(dmem_req), 32'd0);
            chk({tag, "_wait_stall"}, 32'(StallM), (i == rdly) ? 32'd0 : 32'd1);
            chk({tag, "_wait_err"},   32'(BusErrM), 32'd0);
            cyc();
            if (i != rdly) chk({tag, "_wait_bubble"}, 32'(RegWriteW), 32'd0);
        end
        dmem_rvalid = 1'b0;
        sb_check(tag);
    endtask

    initial begin
        rst = 1'b1;
        ALUResultM = 0; WriteDataM = 0; MemWriteM = 0; ResultSrcM = 0;
        LoadTypeM = 0; RegWriteM = 0; RDM = 0; PCPlus4M = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;

        // reset state, with a load presented on the inputs
        ResultSrcM = 2'b01; ALUResultM = 32'h100;
        cyc();
        cyc();
        #4;
        chk("rst_req",   32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_berr",  32'(BusErrM), 32'd0);
        chk("rst_mis",   32'(MisalignM), 32'd0);
        chk("rst_rw",    32'(RegWriteW), 32'd0);
        chk("rst_alu",   ALUResultW, 32'd0);
        chk("rst_rd",    32'(RDW), 32'd0);
        cyc();
        rst = 1'b0;

        // ALU op completes in one cycle
        drive(32'h1234_5678, 0, 2'b00, 2'b00, 3'b000, 3'd1, 5'd7, 32'h44, 3'd1, 32'd0);
        #4;
        chk("alu_stall", 32'(StallM), 32'd0);
        chk("alu_req",   32'(dmem_req), 32'd0);
        cyc();
        sb_check("alu");

        // SW 0x100
        drive(32'h100, 32'hDEAD_BEEF, 2'b11, 2'b00, 3'b010, 3'd0, 5'd0, 32'h48, 3'd0, 32'd0);
        mem_op("sw", 0, 0, 32'h0, 32'h100, 4'b1111, 32'hDEAD_BEEF, 1'b1);

        // LB / LBU 0x103
        drive(32'h103, 0, 2'b00, 2'b01, 3'b000, 3'd1, 5'd5, 32'h4C, 3'd1, 32'hFFFF_FF80);
        mem_op("lb", 0, 0, 32'h80FF_0000, 32'h100, 4'b1111, 32'h0, 1'b0);
        drive(32'h103, 0, 2'b00, 2'b01, 3'b100, 3'd2, 5'd6, 32'h50, 3'd2, 32'h0000_0080);
        mem_op("lbu", 1, 2, 32'h80FF_0000, 32'h100, 4'b1111, 32'h0, 1'b0);

        // LH / LHU 0x102 select the upper halfword
        drive(32'h102, 0, 2'b00, 2'b01, 3'b001, 3'd1, 5'd8, 32'h54, 3'd1, 32'hFFFF_80FF);
        mem_op("lh", 0, 1, 32'h80FF_0000, 32'h100, 4'b1111, 32'h0, 1'b0);
        drive(32'h102, 0, 2'b00, 2'b01, 3'b101, 3'd1, 5'd9, 32'h58, 3'd1, 32'h0000_80FF);
        mem_op("lhu", 0, 0, 32'h80FF_0000, 32'h100, 4'b1111, 32'h0, 1'b0);

        // SH 0x102 with grant delayed 3 cycles (4 REQ cycles)
        drive(32'h102, 32'h0000_1234, 2'b10, 2'b00, 3'b001, 3'd0, 5'd0, 32'h5C, 3'd0, 32'd0);
        mem_op("sh", 3, 0, 32'h0, 32'h100, 4'b1100, 32'h1234_1234, 1'b1);

        // SB 0x101
        drive(32'h101, 32'h0000_00AB, 2'b01, 2'b00, 3'b000, 3'd0, 5'd0, 32'h60, 3'd0, 32'd0);
        mem_op("sb", 0, 0, 32'h0, 32'h100, 4'b0010, 32'hABAB_ABAB, 1'b1);

        // timeout: load granted at once, no rvalid; error on the 8th REQ/WAIT cycle
        drive(32'h300, 0, 2'b00, 2'b01, 3'b010, 3'd1, 5'd3, 32'h64, 3'd0, 32'd0);
        #4;
        chk("tmo_idle_stall", 32'(StallM), 32'd1);
        cyc();
        for (int i = 1; i <= 8; i++) begin
            dmem_gnt = (i == 1);
            #4;
            chk("tmo_berr",  32'(BusErrM), (i == 8) ? 32'd1 : 32'd0);
            chk("tmo_stall", 32'(StallM), (i == 8) ? 32'd0 : 32'd1);
            cyc();
        end
        dmem_gnt = 1'b0;
        sb_check("tmo");
        drive(32'hCAFE_0001, 0, 2'b00, 2'b00, 3'b000, 3'd1, 5'd4, 32'h68, 3'd1, 32'd0);
        #4;
        chk("tmo_after_berr",  32'(BusErrM), 32'd0);
        chk("tmo_after_stall", 32'(StallM), 32'd0);
        cyc();
        sb_check("tmo_alu");

        // LW 0x102: misaligned word
`ifdef MISALIGN_TRAP_EN
        drive(32'h102, 0, 2'b00, 2'b01, 3'b010, 3'd1, 5'd10, 32'h6C, 3'd0, 32'd0);
        #4;
        chk("mis_pulse", 32'(MisalignM), 32'd1);
        chk("mis_req",   32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(StallM), 32'd0);
        cyc();
        chk("mis_clear", 32'(MisalignM), 32'd0);
        sb_check("mis");
`else
        drive(32'h102, 0, 2'b00, 2'b01, 3'b010, 3'd1, 5'd10, 32'h6C, 3'd1, 32'h1122_3344);
        #4;
        chk("mis_none", 32'(MisalignM), 32'd0);
        mem_op("lw_mis", 0, 0, 32'h1122_3344, 32'h100, 4'b1111, 32'h0, 1'b0);
`endif

        // reset in WAIT, then a late rvalid in IDLE
        drive(32'h200, 0, 2'b00, 2'b01, 3'b010, 3'd1, 5'd11, 32'h70, 3'd0, 32'd0);
        cyc();
        dmem_gnt = 1'b1;
        cyc();
        dmem_gnt = 1'b0;
        rst = 1'b1;
        #4;
        chk("rstw_stall", 32'(StallM), 32'd0);
        chk("rstw_req",   32'(dmem_req), 32'd0);
        cyc();
        void'(sb.pop_front());
        drive(32'h0, 0, 2'b00, 2'b00, 3'b000, 3'd0, 5'd0, 32'h0, 3'd0, 32'd0);
        chk("rstw_alu_zero", ALUResultW, 32'd0);
        chk("rstw_pc_zero",  PCPlus4W, 32'd0);
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #4;
        chk("late_rv_stall", 32'(StallM), 32'd0);
        cyc();
        dmem_rvalid = 1'b0;
        sb_check("late_rv");

        // ALU op completes in one cycle after recovery
        drive(32'h0000_00AA, 0, 2'b00, 2'b10, 3'b000, 3'd3, 5'd12, 32'h74, 3'd3, 32'd0);
        #4;
        chk("final_stall", 32'(StallM), 32'd0);
        cyc();
        sb_check("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
